// File: rtl/coffee_pkg.sv
// Shared drink codes and order-controller state encoding.
// latency: n/a. backpressure: n/a.
package coffee_pkg;

    localparam logic [1:0] DRINK_EXPRESSO  = 2'b00;
    localparam logic [1:0] DRINK_CAMOMILA  = 2'b01;
    localparam logic [1:0] DRINK_LEITE     = 2'b10;
    localparam logic [1:0] DRINK_CAPUCCINO = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_PAY = 3'd2,
        BREW     = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronised button level.
// latency: evt is combinational from btn against last cycle's level. backpressure: none.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic evt
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= btn;
    end

    assign evt = btn & ~prev;

endmodule

// File: rtl/coffee_order_fsm.sv
// Coffee order controller: selection, payment wait, timed brew, done hold.
// latency: outputs registered, valid the cycle after the sampling edge. backpressure: none.
module coffee_order_fsm
    import coffee_pkg::*;
#(
    parameter int BREW_CYCLES = 200,
    parameter int DONE_CYCLES = 50,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    input  logic       coin_ok,
    output logic [1:0] drink_code,
    output logic       disp_en,
    output logic       sel_valid,
    output logic       valve_water,
    output logic       valve_milk,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MILK_END  = CNT_W'(BREW_CYCLES / 2);

    state_t           state;
    state_t           nxt_state;
    logic [1:0]       nxt_code;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             ev_next;
    logic             ev_confirm;
    logic             ev_cancel;

    btn_edge u_edge_next    (.clk(clk), .rst_n(rst_n), .btn(btn_next),    .evt(ev_next));
    btn_edge u_edge_confirm (.clk(clk), .rst_n(rst_n), .btn(btn_confirm), .evt(ev_confirm));
    btn_edge u_edge_cancel  (.clk(clk), .rst_n(rst_n), .btn(btn_cancel),  .evt(ev_cancel));

    // Counter defaults to zero so every state entry starts from a cleared count.
    always_comb begin
        nxt_state = state;
        nxt_code  = drink_code;
        nxt_cnt   = '0;
        case (state)
            IDLE: begin
                if (ev_next) begin
                    nxt_state = SELECT;
                    nxt_code  = DRINK_EXPRESSO;
                end
            end
            SELECT: begin
                if (ev_cancel) begin
                    nxt_state = IDLE;
                    nxt_code  = DRINK_EXPRESSO;
                end else if (ev_confirm) begin
                    nxt_state = coin_ok ? BREW : WAIT_PAY;
                end else if (ev_next) begin
                    nxt_code = drink_code + 2'd1;
                end
            end
            WAIT_PAY: begin
                if (ev_cancel) begin
                    nxt_state = IDLE;
                    nxt_code  = DRINK_EXPRESSO;
                end else if (coin_ok) begin
                    nxt_state = BREW;
                end
            end
            BREW: begin
                if (cnt == BREW_LAST) nxt_state = DONE;
                else                  nxt_cnt   = cnt + 1'b1;
            end
            DONE: begin
                if (cnt == DONE_LAST) begin
                    nxt_state = IDLE;
                    nxt_code  = DRINK_EXPRESSO;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_code  = DRINK_EXPRESSO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drink_code  <= DRINK_EXPRESSO;
            cnt         <= '0;
            disp_en     <= 1'b0;
            sel_valid   <= 1'b0;
            valve_water <= 1'b0;
            valve_milk  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nxt_state;
            drink_code  <= nxt_code;
            cnt         <= nxt_cnt;
            disp_en     <= (nxt_state inside {SELECT, WAIT_PAY, DONE});
            sel_valid   <= (nxt_state inside {SELECT, WAIT_PAY, DONE});
            valve_water <= (nxt_state == BREW);
            valve_milk  <= (nxt_state == BREW) && nxt_code[1] && (nxt_cnt < MILK_END);
            busy        <= (nxt_state == BREW);
            done        <= (nxt_state == DONE);
        end
    end

endmodule

// File: tb/tb_coffee_order_fsm.sv
// Self-checking bench for coffee_order_fsm against a phase/time-left reference model.
module tb_coffee_order_fsm;

    localparam int BREW = 8;
    localparam int DONE = 4;
    localparam int P_IDLE = 0, P_SEL = 1, P_WAIT = 2, P_BREW = 3, P_DONE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_confirm = 1'b0;
    logic       btn_cancel = 1'b0;
    logic       coin_ok = 1'b0;
    logic [1:0] drink_code;
    logic       disp_en, sel_valid, valve_water, valve_milk, busy, done;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    int m_phase, m_code, m_left;
    bit m_pn, m_pc, m_px;

    coffee_order_fsm #(.BREW_CYCLES(BREW), .DONE_CYCLES(DONE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_next(btn_next), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
        .coin_ok(coin_ok), .drink_code(drink_code), .disp_en(disp_en),
        .sel_valid(sel_valid), .valve_water(valve_water), .valve_milk(valve_milk),
        .busy(busy), .done(done)
    );

    assign obs = {drink_code, disp_en, sel_valid, valve_water, valve_milk, busy, done};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE; m_code = 0; m_left = 0;
        m_pn = 0; m_pc = 0; m_px = 0;
    endtask

    task automatic model_step(input bit n, input bit c, input bit x, input bit k);
        bit en, ec, ex;
        en = n && !m_pn; ec = c && !m_pc; ex = x && !m_px;
        m_pn = n; m_pc = c; m_px = x;
        case (m_phase)
            P_IDLE: if (en) begin m_phase = P_SEL; m_code = 0; end
            P_SEL: begin
                if (ex) begin m_phase = P_IDLE; m_code = 0; end
                else if (ec) begin
                    if (k) begin m_phase = P_BREW; m_left = BREW; end
                    else m_phase = P_WAIT;
                end else if (en) m_code = (m_code + 1) % 4;
            end
            P_WAIT: begin
                if (ex) begin m_phase = P_IDLE; m_code = 0; end
                else if (k) begin m_phase = P_BREW; m_left = BREW; end
            end
            P_BREW: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_DONE; m_left = DONE; end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_IDLE; m_code = 0; end
            end
        endcase
    endtask

    function automatic logic [7:0] exp_vec();
        logic brew, shown, milk;
        brew  = (m_phase == P_BREW);
        shown = (m_phase == P_SEL) || (m_phase == P_WAIT) || (m_phase == P_DONE);
        milk  = brew && (m_code >= 2) && ((BREW - m_left) < BREW / 2);
        return {2'(m_code), shown, shown, brew, milk, brew, (m_phase == P_DONE)};
    endfunction

    // Drive levels just after an edge, let the next edge sample them, then settle.
    task automatic tick(input bit n, input bit c, input bit x, input bit k);
        btn_next = n; btn_confirm = c; btn_cancel = x; coin_ok = k;
        @(posedge clk);
        model_step(n, c, x, k);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'h00); end
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle obs=%b exp=%b", obs, 8'h00); end
        tick(1, 0, 0, 0);
        checks++;
        if (obs !== 8'b00_1_1_0_0_0_0) begin errors++; $display("FAIL first_next obs=%b exp=%b", obs, 8'b00110000); end
        tick(0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL first_next_hold obs=%b exp=%b", obs, exp_vec()); end
    endtask

    task automatic test_next_wrap();
        int seq [5];
        seq = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (drink_code !== 2'(seq[i])) begin errors++; $display("FAIL next_seq i=%0d code=%b exp=%0d", i, drink_code, seq[i]); end
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL next_gap i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL next_hold i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
        tick(0, 0, 0, 0);
        checks++;
        if (drink_code !== 2'b10) begin errors++; $display("FAIL hold_one_step code=%b exp=10", drink_code); end
    endtask

    task automatic test_brew_milk();
        int wn, mn, dn;
        wn = 0; mn = 0; dn = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) tick(0, 1, 0, 1);
            else        tick(0, 0, 0, 0);
            wn += int'(valve_water); mn += int'(valve_milk); dn += int'(done);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL brew_cycle i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
        checks++;
        if (wn != BREW) begin errors++; $display("FAIL water_cycles got=%0d exp=%0d", wn, BREW); end
        checks++;
        if (mn != BREW / 2) begin errors++; $display("FAIL milk_cycles got=%0d exp=%0d", mn, BREW / 2); end
        checks++;
        if (dn != DONE) begin errors++; $display("FAIL done_cycles got=%0d exp=%0d", dn, DONE); end
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL after_done obs=%b exp=%b", obs, 8'h00); end
    endtask

    task automatic test_wait_pay();
        int wn, mn;
        wn = 0; mn = 0;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(bit'(i % 2), 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL wait_pay i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
        checks++;
        if (obs !== 8'b00_1_1_0_0_0_0) begin errors++; $display("FAIL wait_pay_held obs=%b exp=%b", obs, 8'b00110000); end
        for (int i = 0; i < 13; i++) begin
            tick(0, 0, 0, bit'(i == 0));
            wn += int'(valve_water); mn += int'(valve_milk);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL paid_brew i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
        checks++;
        if (wn != BREW || mn != 0) begin errors++; $display("FAIL expresso_valves water=%0d milk=%0d exp=%0d,0", wn, mn, BREW); end
    endtask

    task automatic test_priority();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL cancel_beats_coin obs=%b exp=%b", obs, 8'h00); end
        tick(0, 0, 0, 1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL no_brew_after_cancel busy=%b exp=0", busy); end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 1);
        checks++;
        if (drink_code !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL confirm_beats_next code=%b busy=%b exp=00,1", drink_code, busy); end
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL prio_drain i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            tick(1, 0, 0, 0);
        end
        tick(0, 1, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec() || valve_milk !== 1'b1) begin errors++; $display("FAIL pre_reset_brew obs=%b exp=%b", obs, exp_vec()); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL async_valve_drop obs=%b exp=%b", obs, 8'h00); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick(1, 0, 0, 0);
        checks++;
        if (obs !== 8'b00_1_1_0_0_0_0) begin errors++; $display("FAIL fresh_select obs=%b exp=%b", obs, 8'b00110000); end
    endtask

    task automatic test_random();
        bit n, c, x, k;
        n = 0; c = 0; x = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) n = ~n;
            if ($urandom_range(0, 4) == 0) c = ~c;
            if ($urandom_range(0, 11) == 0) x = ~x;
            k = ($urandom_range(0, 2) == 0);
            tick(n, c, x, k);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_brew_milk();
        test_wait_pay();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coffee_order_fsm.md
Name: coffee_order_fsm

Overview:
- Order controller that sits directly upstream of the drink display decoder.
- Walks the user through drink selection, payment wait and brew timing.
- Drives the decoder's drink-select bits (E,F), display enable (B) and selection-valid (Y).
- Also drives the water and milk valves for the selected drink.

Parameters:
- BREW_CYCLES, 200, clock cycles spent in BREW (minimum 2).
- DONE_CYCLES, 50, clock cycles the DONE indication is held (minimum 1).
- CNT_W, 16, counter width; must hold max(BREW_CYCLES, DONE_CYCLES).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_next  in  1  already-synchronised, debounced level; a rising edge advances the selection.
- btn_confirm  in  1  synchronised level; a rising edge confirms the selection.
- btn_cancel  in  1  synchronised level; a rising edge aborts the order.
- coin_ok  in  1  level; payment accepted.
- drink_code  out  2  00 expresso, 01 camomila, 10 leite, 11 capuccino. Bit1 feeds decoder E, bit0 feeds decoder F.
- disp_en  out  1  decoder B input.
- sel_valid  out  1  decoder Y input.
- valve_water  out  1  water valve drive.
- valve_milk  out  1  milk valve drive.
- busy  out  1  high in BREW.
- done  out  1  high in DONE.

Behaviour:
- Clock and reset
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - Reset forces: state=IDLE, drink_code=00, counter=0, edge-detect history registers=0.
  - After reset, all outputs are 0.
- Edge detection
  - Each button is registered once per cycle.
  - An event is cur=1 and prev=1'b0.
  - A held button produces exactly one event.
- Event priority when events coincide in one cycle: cancel > confirm > next.
- Moore outputs, decoded from registered state. Everything below takes effect at the clock edge where the event is sampled.
- States and transitions:
  - IDLE: disp_en=0, sel_valid=0.
    - next event -> SELECT, drink_code:=00.
    - confirm and cancel are ignored.
  - SELECT: disp_en=1, sel_valid=1.
    - next -> drink_code+1, wrapping 11->00.
    - confirm -> BREW if coin_ok=1 that cycle, otherwise WAIT_PAY.
    - cancel -> IDLE, drink_code:=00.
  - WAIT_PAY: disp_en=1, sel_valid=1, drink_code frozen.
    - coin_ok=1 -> BREW.
    - cancel -> IDLE, drink_code:=00. Cancel wins if coin_ok and cancel coincide.
    - next is ignored.
  - BREW: busy=1, valve_water=1, counter counts 0..BREW_CYCLES-1.
    - valve_milk=1 only when drink_code[1]=1 and counter < BREW_CYCLES/2 (integer division).
    - Every button is ignored; a brew cannot be cancelled.
    - At counter==BREW_CYCLES-1 -> DONE, counter:=0.
  - DONE: done=1, valves off, disp_en=1, sel_valid=1.
    - Counter counts to DONE_CYCLES-1, then -> IDLE with drink_code:=00.
    - Buttons are ignored.
- Counter is cleared on every state entry.
- Counter width is CNT_W. A compare beyond the range never occurs, given the parameter legality rules above.
- Brew duration: BREW is occupied for exactly BREW_CYCLES cycles, and valve_water is high for exactly that count.
- coin_ok is not latched. It is sampled only in SELECT (on confirm) and in WAIT_PAY.
- Reset asserted mid-brew drops the valves immediately (asynchronous) and returns to IDLE.

Decomposition:
- Shared package coffee_pkg holds:
  - drink code constants: DRINK_EXPRESSO=2'b00, DRINK_CAMOMILA=2'b01, DRINK_LEITE=2'b10, DRINK_CAPUCCINO=2'b11;
  - state encoding constants IDLE, SELECT, WAIT_PAY, BREW, DONE (3-bit).
- One sub-module: btn_edge (a 1-bit register plus rising-edge pulse), instantiated three times.
- The FSM and the counter stay in coffee_order_fsm.

Test Plan:
- Reset with all inputs 0, then pulse btn_next once -> next cycle state SELECT, drink_code=00, disp_en=1, sel_valid=1.
- In SELECT, 5 separate btn_next pulses -> drink_code sequence 01,10,11,00,01. Holding btn_next high for 10 cycles advances it by exactly 1.
- Use BREW_CYCLES=8, DONE_CYCLES=4, drink_code=10, coin_ok=1, then a confirm pulse:
  - BREW for 8 cycles, valve_water=1 for 8 cycles, valve_milk=1 for the first 4;
  - then done=1 for 4 cycles;
  - then IDLE with all outputs 0.
- drink_code=00, confirm with coin_ok=0 -> WAIT_PAY held 20 cycles. coin_ok=1 -> BREW, valve_milk stays 0 throughout.
- In WAIT_PAY, assert cancel and coin_ok in the same cycle -> IDLE, drink_code=00, no BREW. Confirm and next in the same cycle in SELECT -> confirm wins.
- rst_n low for 1 cycle at BREW counter=3 -> valves drop in the same cycle with no clock edge, state IDLE. btn_next then starts a fresh selection at 00.
